// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS-like datapath. Every output is
// decoded from the registered state. The one exception is IRWrite/PCWrite in
// FETCH, which are qualified by MemReady so the PC advances exactly once per
// fetch however long memory takes.
//
// Configuration macro: MULTICYCLE_JAL_EN
//   defined   -> OP=000011 (jal) executes through the JAL state (State=13)
//   undefined -> the JAL state does not exist and OP=000011 traps
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCondEQ,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Illegal,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [3:0] State
);

    // Opcodes understood by the decoder.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation codes driven towards the ALU control.
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;

    // State encodings are visible on State, so they are fixed explicitly.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        RTEX   = 4'd7,
        RTWB   = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        IMMEX  = 4'd11,
        IMMWB  = 4'd12,
`ifdef MULTICYCLE_JAL_EN
        JAL    = 4'd13,
`endif
        TRAP   = 4'd14
    } stateT;

    stateT stateR;
    stateT stateNextS;

    // Dispatch from DECODE: opcode to the first execution state.
    function automatic stateT decodeOp(input logic [5:0] op);
        stateT target;
        case (op)
            OP_LW, OP_SW:     target = MEMADR;
            OP_RTYPE:         target = RTEX;
            OP_BEQ, OP_BNE:   target = BRANCH;
            OP_J:             target = JUMP;
            OP_ADDI, OP_ORI:  target = IMMEX;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:           target = JAL;
`endif
            default:          target = TRAP;
        endcase
        return target;
    endfunction

    // State register; reset drops straight back to IDLE without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Next-state selection and output decode of the current state.
    always_comb begin
        stateNextS    = IDLE;
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        Illegal       = 1'b0;
        ALUSrcB       = 2'd0;
        PCSource      = 2'd0;
        ALUOp         = ALU_ADD;

        case (stateR)
            IDLE: begin
                stateNextS = FETCH;
            end

            FETCH: begin
                // PC+4 is computed every cycle but only committed with the word.
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
                ALUSrcB = 2'd1;
                ALUOp   = ALU_ADD;
                if (MemReady) begin
                    stateNextS = DECODE;
                end else begin
                    stateNextS = FETCH;
                end
            end

            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ALUSrcB    = 2'd3;
                ALUOp      = ALU_ADD;
                stateNextS = decodeOp(OP);
            end

            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = ALU_ADD;
                if (OP == OP_LW) begin
                    stateNextS = MEMRD;
                end else begin
                    stateNextS = MEMWR;
                end
            end

            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    stateNextS = MEMWB;
                end else begin
                    stateNextS = MEMRD;
                end
            end

            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                stateNextS = FETCH;
            end

            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    stateNextS = FETCH;
                end else begin
                    stateNextS = MEMWR;
                end
            end

            RTEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd0;
                ALUOp      = ALU_FUNCT;
                stateNextS = RTWB;
            end

            RTWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                stateNextS = FETCH;
            end

            BRANCH: begin
                // Only the condition bit matching the opcode may update the PC.
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'd0;
                ALUOp         = ALU_SUB;
                PCSource      = 2'd1;
                PCWriteCondEQ = (OP == OP_BEQ);
                PCWriteCondNE = (OP == OP_BNE);
                stateNextS    = FETCH;
            end

            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'd2;
                stateNextS = FETCH;
            end

            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                if (OP == OP_ORI) begin
                    ALUOp = ALU_OR;
                end else begin
                    ALUOp = ALU_ADD;
                end
                stateNextS = IMMWB;
            end

            IMMWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b0;
                stateNextS = FETCH;
            end

`ifdef MULTICYCLE_JAL_EN
            JAL: begin
                // Datapath forces the write register to 31 while State=13.
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                PCSource   = 2'd2;
                MemtoReg   = 1'b0;
                RegDst     = 1'b0;
                stateNextS = FETCH;
            end
`endif

            TRAP: begin
                // Flag the illegal opcode and resume fetching without side effects.
                Illegal    = 1'b1;
                stateNextS = FETCH;
            end

            default: begin
                // Unused encodings recover through IDLE with all outputs quiet.
                stateNextS = IDLE;
            end
        endcase
    end

    assign State = stateR;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port OP, input, 6 bits: opcode field of the instruction register.
REQ-004 The block SHALL have port MemReady, input, 1 bit: memory completion handshake.
REQ-005 The block SHALL have 1-bit outputs PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA and Illegal.
REQ-006 The block SHALL have outputs ALUSrcB (2 bits; 0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2), PCSource (2 bits; 0=ALU, 1=ALUOut, 2=jump target) and ALUOp (4 bits).
REQ-007 The block SHALL have output State, 4 bits: current state encoding, for debug.

Function
REQ-008 The block SHALL be a Moore FSM; all outputs are combinational decodes of the registered state only, and every output is 0 unless listed for that state.
REQ-009 The states SHALL be encoded: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEX=7, RTWB=8, BRANCH=9, JUMP=10, IMMEX=11, IMMWB=12, JAL=13, TRAP=14.
REQ-010 IDLE SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-011 FETCH SHALL assert MemRead, IRWrite, PCWrite, ALUSrcB=1, ALUOp=0000 (add); it holds while MemReady=0 and goes to DECODE when MemReady=1.
REQ-012 IRWrite and PCWrite in FETCH SHALL be qualified by MemReady; PC advances exactly once per fetch regardless of wait cycles.
REQ-013 DECODE SHALL drive ALUSrcB=3, ALUOp=0000 (branch target into ALUOut) and branch on OP: 100011/101011->MEMADR, 000000->RTEX, 000100/000101->BRANCH, 000010->JUMP, 001000/001101->IMMEX, 000011->JAL, any other->TRAP.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=0000; goes to MEMRD if OP=100011, else MEMWR.
REQ-015 MEMRD SHALL assert MemRead and IorD, holding until MemReady=1, then MEMWB; MEMWB asserts RegWrite and MemtoReg (RegDst=0), then FETCH.
REQ-016 MEMWR SHALL assert MemWrite and IorD, holding until MemReady=1, then FETCH.
REQ-017 RTEX SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=0010 (funct-decoded), then RTWB; RTWB asserts RegWrite and RegDst, then FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=0001 (sub), PCSource=1, and PCWriteCondEQ if OP=000100 or PCWriteCondNE if OP=000101; then FETCH.
REQ-019 JUMP SHALL assert PCWrite with PCSource=2, then FETCH.
REQ-020 IMMEX SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=0000 for 001000 or 0011 (or-imm) for 001101, then IMMWB; IMMWB asserts RegWrite with RegDst=0, then FETCH.
REQ-021 TRAP SHALL assert Illegal for exactly one cycle, then go to FETCH with no register, memory or PC write.
REQ-022 Instruction latency SHALL be, with MemReady constantly 1: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3, jal 3 cycles.
REQ-023 Outputs of the state being left SHALL remain valid for its full final cycle; no output glitches on a MemReady transition except the qualified bits in REQ-012.

Reset
REQ-024 reset=1 SHALL force state to IDLE immediately, independent of clk, so all outputs read 0 during reset.
REQ-025 Reset asserted mid-instruction, including during a MemReady wait, SHALL abandon the instruction with no further writes; execution restarts at IDLE then FETCH.

Configuration
REQ-026 Macro MULTICYCLE_JAL_EN defined: DECODE maps OP=000011 to JAL, which asserts RegWrite, PCWrite, PCSource=2 and a link-select (MemtoReg=0, RegDst=0, write register forced to 31 by the datapath via State=13), then FETCH.
REQ-027 Macro MULTICYCLE_JAL_EN undefined: state JAL SHALL not exist; OP=000011 SHALL go to TRAP.

Verification
REQ-028 Reset released, MemReady=1, OP=000000 -> states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in cycle 5.
REQ-029 OP=100011, MemReady held 0 for 3 cycles in FETCH and 2 in MEMRD -> PCWrite asserted exactly once; MEMWB reached after 10 cycles total from FETCH entry.
REQ-030 OP=000101 -> BRANCH asserts PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=0001, PCSource=1; back in FETCH after 3 cycles.
REQ-031 OP=111111 -> TRAP, Illegal=1 for one cycle, RegWrite, MemWrite and PCWrite stay 0, next state FETCH.
REQ-032 reset pulsed during MEMWR wait -> State=0 asynchronously, MemWrite drops to 0 before the next clk edge.
REQ-033 OP=000011 with MULTICYCLE_JAL_EN -> State=13 with RegWrite=1 and PCWrite=1; without it -> State=14 and Illegal=1.
